// File: rtl/cv32e40p_ft_pkg.sv
// rtl/cv32e40p_ft_pkg.sv - shared types and replica selection helper for the redundancy manager
package cv32e40p_ft_pkg;

    typedef enum logic [1:0] {
        FT_TMR    = 2'd0,
        FT_DMR    = 2'd1,
        FT_SINGLE = 2'd2,
        FT_NONE   = 2'd3
    } ft_mode_e;

    typedef enum logic [1:0] {
        RCFG_ACTIVE  = 2'd0,
        RCFG_PENDING = 2'd1,
        RCFG_SWITCH  = 2'd2
    } ft_rcfg_state_e;

    typedef struct packed {
        logic [2:0] p2;
        logic [2:0] p1;
        logic [2:0] p0;
        logic [1:0] count;
        ft_mode_e   mode;
    } ft_sel_t;

    // Lowest-index healthy units fill voter ports 0..2; fewer than three
    // healthy units duplicate the last found index into the remaining ports.
    function automatic ft_sel_t ft_first3_healthy(input logic [7:0] healthy);
        ft_sel_t    s;
        logic [1:0] n;
        s = '0;
        n = 2'd0;
        for (int i = 0; i < 8; i++) begin
            if (healthy[i] && n != 2'd3) begin
                case (n)
                    2'd0:    s.p0 = 3'(i);
                    2'd1:    s.p1 = 3'(i);
                    default: s.p2 = 3'(i);
                endcase
                n = n + 2'd1;
            end
        end
        case (n)
            2'd3: s.mode = FT_TMR;
            2'd2: begin
                s.p2   = s.p1;
                s.mode = FT_DMR;
            end
            2'd1: begin
                s.p1   = s.p0;
                s.p2   = s.p0;
                s.mode = FT_SINGLE;
            end
            default: s.mode = FT_NONE;
        endcase
        s.count = n;
        return s;
    endfunction

endpackage

// File: rtl/cv32e40p_ft_err_counter.sv
// rtl/cv32e40p_ft_err_counter.sv - leaky saturating error counter with sticky fault flag
module cv32e40p_ft_err_counter
    import cv32e40p_ft_pkg::*;
#(
    parameter int CNT_W        = 4,
    parameter int FAULT_THRESH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic update,
    input  logic mismatch,
    input  logic force_faulty,
    input  logic clear,
    output logic faulty,
    output logic faulty_next
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] THRESH  = CNT_W'(FAULT_THRESH);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             faulty_q, faulty_d;

    // Leak toward zero on agreement, climb on disagreement; a faulty unit freezes.
    always_comb begin
        cnt_d    = cnt_q;
        faulty_d = faulty_q;
        if (clear) begin
            cnt_d    = '0;
            faulty_d = 1'b0;
        end else begin
            if (update && !faulty_q) begin
                if (mismatch) begin
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                end else begin
                    cnt_d = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
                end
                if (cnt_d >= THRESH) begin
                    faulty_d = 1'b1;
                end
            end
            if (force_faulty) begin
                faulty_d = 1'b1;
            end
        end
    end

    // Counter and fault flag registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            faulty_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            faulty_q <= faulty_d;
        end
    end

    assign faulty      = faulty_q;
    assign faulty_next = faulty_d;

endmodule

// File: rtl/cv32e40p_redundancy_manager_ft.sv
// rtl/cv32e40p_redundancy_manager_ft.sv - replica health tracking and safe-point voter reconfiguration
module cv32e40p_redundancy_manager_ft
    import cv32e40p_ft_pkg::*;
#(
    parameter int N_UNITS      = 4,
    parameter int CNT_W        = 4,
    parameter int FAULT_THRESH = 8,
    parameter int IDX_W        = $clog2(N_UNITS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 check_valid_i,
    input  logic [N_UNITS-1:0]   mismatch_i,
    input  logic [N_UNITS-1:0]   force_faulty_i,
    input  logic                 clear_faults_i,
    input  logic                 idle_i,
    output logic [N_UNITS-1:0]   faulty_o,
    output logic [N_UNITS-1:0]   enable_o,
    output logic [3*IDX_W-1:0]   sel_idx_o,
    output logic [1:0]           mode_o,
    output logic                 totally_defective_o,
    output logic                 reconfig_pending_o,
    output logic                 reconfig_done_o
);

    ft_rcfg_state_e state_q, state_d;
    logic [N_UNITS-1:0] faulty_next;
    logic               fault_change;
    logic [7:0]         healthy;
    ft_sel_t            new_sel;
    logic [N_UNITS-1:0] new_enable;

    for (genvar k = 0; k < N_UNITS; k++) begin : g_cnt
        cv32e40p_ft_err_counter #(
            .CNT_W        (CNT_W),
            .FAULT_THRESH (FAULT_THRESH)
        ) u_cnt (
            .clk          (clk),
            .rst_n        (rst_n),
            .update       (enable_o[k] && check_valid_i),
            .mismatch     (mismatch_i[k]),
            .force_faulty (force_faulty_i[k]),
            .clear        (clear_faults_i),
            .faulty       (faulty_o[k]),
            .faulty_next  (faulty_next[k])
        );
    end

    // A clear always requests a reselection, even if nothing was faulty.
    assign fault_change = (faulty_next != faulty_o) || clear_faults_i;

    // Reconfiguration state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RCFG_ACTIVE;
        end else begin
            state_q <= state_d;
        end
    end

    // Wait for a safe point; a fault landing during SWITCH queues another pass.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RCFG_ACTIVE:  if (fault_change) state_d = RCFG_PENDING;
            RCFG_PENDING: if (idle_i) state_d = RCFG_SWITCH;
            RCFG_SWITCH:  state_d = fault_change ? RCFG_PENDING : RCFG_ACTIVE;
            default:      state_d = RCFG_ACTIVE;
        endcase
    end

    // Status outputs decoded from state.
    always_comb begin
        reconfig_pending_o = (state_q == RCFG_PENDING) || (state_q == RCFG_SWITCH);
        reconfig_done_o    = (state_q == RCFG_SWITCH);
    end

    // Candidate selection from the current healthy set.
    always_comb begin
        healthy              = '0;
        healthy[N_UNITS-1:0] = ~faulty_o;
        new_sel              = ft_first3_healthy(healthy);
        for (int k = 0; k < N_UNITS; k++) begin
            new_enable[k] = (new_sel.count != 2'd0) &&
                            ((new_sel.p0 == 3'(k)) || (new_sel.p1 == 3'(k)) || (new_sel.p2 == 3'(k)));
        end
    end

    // The live selection only changes on the SWITCH cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_idx_o           <= {IDX_W'(2), IDX_W'(1), IDX_W'(0)};
            enable_o            <= N_UNITS'(3'b111);
            mode_o              <= FT_TMR;
            totally_defective_o <= 1'b0;
        end else if (state_q == RCFG_SWITCH) begin
            sel_idx_o           <= {IDX_W'(new_sel.p2), IDX_W'(new_sel.p1), IDX_W'(new_sel.p0)};
            enable_o            <= new_enable;
            mode_o              <= new_sel.mode;
            totally_defective_o <= (new_sel.mode == FT_NONE);
        end
    end

endmodule

// File: tb/tb_cv32e40p_redundancy_manager_ft.sv
// tb/tb_cv32e40p_redundancy_manager_ft.sv - scoreboard bench for the redundancy manager
module tb_cv32e40p_redundancy_manager_ft;

    localparam int N = 4;
    localparam int IW = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             check_valid;
    logic [N-1:0]     mismatch;
    logic [N-1:0]     force_faulty;
    logic             clear_faults;
    logic             idle;
    logic [N-1:0]     faulty;
    logic [N-1:0]     enable;
    logic [3*IW-1:0]  sel_idx;
    logic [1:0]       mode;
    logic             totally_defective;
    logic             reconfig_pending;
    logic             reconfig_done;

    cv32e40p_redundancy_manager_ft #(.N_UNITS(N), .CNT_W(4), .FAULT_THRESH(8)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .check_valid_i       (check_valid),
        .mismatch_i          (mismatch),
        .force_faulty_i      (force_faulty),
        .clear_faults_i      (clear_faults),
        .idle_i              (idle),
        .faulty_o            (faulty),
        .enable_o            (enable),
        .sel_idx_o           (sel_idx),
        .mode_o              (mode),
        .totally_defective_o (totally_defective),
        .reconfig_pending_o  (reconfig_pending),
        .reconfig_done_o     (reconfig_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3*IW-1:0] sel;
        logic [N-1:0]    en;
        logic [1:0]      md;
        logic            tdef;
        logic [N-1:0]    flt;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;
    int   done_count = 0;
    logic done_d = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3*IW-1:0] sel3(input int p2, input int p1, input int p0);
        return {IW'(p2), IW'(p1), IW'(p0)};
    endfunction

    task automatic push(input logic [3*IW-1:0] s, input logic [N-1:0] e, input logic [1:0] m,
                        input logic t, input logic [N-1:0] f);
        exp_t x;
        x.sel = s; x.en = e; x.md = m; x.tdef = t; x.flt = f;
        expq.push_back(x);
    endtask

    // Outputs are compared the cycle after the done pulse, when the new selection is live.
    always @(negedge clk) begin
        exp_t x;
        if (!rst_n) begin
            done_d = 1'b0;
        end else begin
            if (done_d) begin
                if (expq.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    x = expq.pop_front();
                    check("sel",    32'(sel_idx), 32'(x.sel));
                    check("enable", 32'(enable), 32'(x.en));
                    check("mode",   32'(mode), 32'(x.md));
                    check("tdef",   32'(totally_defective), 32'(x.tdef));
                    check("faulty", 32'(faulty), 32'(x.flt));
                end
            end
            if (reconfig_done) done_count++;
            done_d = reconfig_done;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_sb();
        int i;
        for (i = 0; i < 60 && expq.size() != 0; i++) tick();
        check("sb_drain", 32'(expq.size()), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; check_valid = 1'b0; mismatch = '0; force_faulty = '0;
        clear_faults = 1'b0; idle = 1'b0;
        tick(2);
        expq.delete();
        rst_n = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sel"},     32'(sel_idx), 32'(sel3(2, 1, 0)));
        check({tag, "_enable"},  32'(enable), 32'h7);
        check({tag, "_mode"},    32'(mode), 0);
        check({tag, "_faulty"},  32'(faulty), 0);
        check({tag, "_tdef"},    32'(totally_defective), 0);
        check({tag, "_pending"}, 32'(reconfig_pending), 0);
        check({tag, "_done"},    32'(reconfig_done), 0);
    endtask

    initial begin
        int d0;
        do_reset();
        @(negedge clk);
        check_reset_outputs("reset");
        tick();

        // Alternating mismatch/clean on unit 0, plus constant mismatch on disabled unit 3.
        check_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            mismatch = (i % 2 == 0) ? 4'b1001 : 4'b1000;
            tick();
        end
        check_valid = 1'b0; mismatch = '0;
        tick(3);
        check("leaky_faulty", 32'(faulty), 0);
        check("leaky_no_done", 32'(done_count), 0);
        check("leaky_pending", 32'(reconfig_pending), 0);

        // Seven mismatches on unit 1 stay below threshold, the eighth declares it.
        idle = 1'b1;
        check_valid = 1'b1; mismatch = 4'b0010;
        tick(7);
        check("below_thresh", 32'(faulty), 0);
        push(sel3(3, 2, 0), 4'b1101, 2'd0, 1'b0, 4'b0010);
        tick();
        check_valid = 1'b0; mismatch = '0;
        check("at_thresh", 32'(faulty), 32'h2);
        wait_sb();
        check("one_done", 32'(done_count), 1);

        // Force units 0,1 with no safe point: old selection stays live.
        do_reset();
        force_faulty = 4'b0011;
        tick();
        force_faulty = '0;
        tick(20);
        check("hold_pending", 32'(reconfig_pending), 1);
        check("hold_sel", 32'(sel_idx), 32'(sel3(2, 1, 0)));
        check("hold_enable", 32'(enable), 32'h7);
        check("hold_faulty", 32'(faulty), 32'h3);
        push(sel3(3, 3, 2), 4'b1100, 2'd1, 1'b0, 4'b0011);
        idle = 1'b1;
        wait_sb();

        // Single survivor: all ports on unit 3.
        force_faulty = 4'b0100;
        push(sel3(3, 3, 3), 4'b1000, 2'd2, 1'b0, 4'b0111);
        tick();
        force_faulty = '0;
        wait_sb();

        // All faulty, then clear back to TMR.
        force_faulty = 4'b1000;
        push(sel3(0, 0, 0), 4'b0000, 2'd3, 1'b1, 4'b1111);
        tick();
        force_faulty = '0;
        wait_sb();
        clear_faults = 1'b1;
        push(sel3(2, 1, 0), 4'b0111, 2'd0, 1'b0, 4'b0000);
        tick();
        clear_faults = 1'b0;
        wait_sb();

        // Reset while pending aborts the reconfiguration.
        do_reset();
        force_faulty = 4'b0100;
        tick();
        force_faulty = '0;
        tick(3);
        check("pre_abort_pending", 32'(reconfig_pending), 1);
        check("pre_abort_faulty", 32'(faulty), 32'h4);
        d0 = done_count;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("abort");
        tick(4);
        check("abort_no_done", 32'(done_count), 32'(d0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
